ext_bus_responder: RTL and testbench
====================================

# ext_bus_responder

Target side of the CPU's external pin bus (rw / 16-bit addr / 16-bit data / lock handshake, plus the inta/intb interrupt lines). It decodes an address window and serves single-word reads and writes from a local word memory. An optional interrupt register drives the CPU interrupt inputs. It sits on the board/fabric side of the bus, and the top level converts its split output/enable pairs into tri-state pins.

## Interface
Parameters:
- BASE_ADDR, 16'h8000: first word address of the decoded window.
- ADDR_BITS, 8: window/memory depth is 2^ADDR_BITS words of 16 bits.
- WAIT_CYCLES, 2: cycles in WAIT before acknowledge; legal range 1..15.
- INT_ADDR, 16'h7FFF: interrupt register address; must lie outside the window.

Ports:
- clk  in  1  single clock (CPU core clock domain).
- n_rst  in  1  asynchronous, active-low reset.
- i_rw  in  1  1 = read, 0 = write; sampled with the request.
- i_addr  in  16  word address.
- i_data  in  16  write data from the pin bus.
- o_data  out  16  read data.
- o_data_oe  out  1  enable for driving the data pins.
- i_lock  in  1  lock pin level.
- o_lock  out  1  lock level to drive.
- o_lock_oe  out  1  enable for driving the lock pin.
- o_inta  out  1  interrupt A level.
- o_intb  out  1  interrupt B level.

## Operation
- FSM states: IDLE, WAIT, ACK, TURN.
- IDLE:
  - All enables are 0.
  - If i_lock==1 and the address hits (window, or INT_ADDR when interrupts are enabled), latch rw/addr/data and go to WAIT.
  - A miss is ignored: stay in IDLE, no acknowledge.
- WAIT:
  - On the first WAIT cycle, a write is committed to memory or the interrupt register, or the memory read is issued.
  - A counter runs WAIT_CYCLES cycles, then the FSM goes to ACK.
- ACK (1 cycle):
  - o_lock_oe=1, o_lock=1.
  - For a read, o_data_oe=1 and o_data=read word.
  - For a write, o_data_oe=0.
- TURN (1 cycle):
  - o_lock_oe=1, o_lock=0 (actively discharges lock), o_data_oe=0.
  - Then IDLE.
- i_lock is ignored outside IDLE. The initiator must release lock the cycle after its request and keep it released until it sees ACK.
- Memory index = i_addr − BASE_ADDR, truncated to ADDR_BITS. The hit test is BASE_ADDR ≤ addr < BASE_ADDR + 2^ADDR_BITS, computed in 17 bits so the window end does not wrap past 16'hFFFF.
- Memory contents are not reset. Tests must write a location before reading it.

## Timing
- Request sampled at T0. WAIT runs T1..T(WAIT_CYCLES). ACK at T(WAIT_CYCLES+1), then TURN. IDLE at T(WAIT_CYCLES+3), which is the earliest cycle a new request is accepted.
- Read data is valid exactly during the ACK cycle. A write is visible to a read request sampled at any later T0.
- Reset values:
  - State IDLE.
  - o_data=0, o_data_oe=0, o_lock=0, o_lock_oe=0.
  - o_inta=0, o_intb=0.
  - Wait counter 0.
- Reset asserted mid-transaction: all enables drop asynchronously in the same cycle. A write already committed in WAIT stays written. An un-acknowledged read is lost.
- Lock still high in the ACK cycle (initiator fault): the ACK is still driven and no new request is latched.

## Configuration
- EXT_BUS_INT_EN defined:
  - INT_ADDR is decoded.
  - A write sets o_inta=data[0] and o_intb=data[1]; these are levels held until rewritten.
  - A read returns {14'b0, o_intb, o_inta}.
- EXT_BUS_INT_EN undefined:
  - The interrupt register and its decode are removed.
  - INT_ADDR is treated as a miss (no acknowledge).
  - o_inta and o_intb are tied 0.

## Structure
- Package ext_bus_pkg holds:
  - the FSM state encoding (IDLE/WAIT/ACK/TURN);
  - RW_READ=1 and RW_WRITE=0;
  - the lock idle/ack level constants.
- Sub-module ext_bus_sram: single-port synchronous memory, 2^ADDR_BITS×16, write-enable, registered read (1-cycle latency). It is inferred as block/distributed RAM. WAIT_CYCLES≥1 covers its read latency.
- The FSM, wait counter, address decode and interrupt register live in ext_bus_responder.

## Test plan
- Reset: n_rst low for 3 cycles mid-WAIT -> all outputs 0 immediately, state IDLE, the next valid request is accepted normally.
- Write then read (WAIT_CYCLES=2): write 16'hA5C3 to 16'h8010 at T0 -> lock ack (oe=1, o_lock=1) at T3, lock driven 0 at T4. Read of 16'h8010 -> o_data=16'hA5C3 with o_data_oe=1 only at its T3.
- Window boundaries: write/read at 16'h8000 and 16'h80FF -> acknowledged, data round-trips. Requests at 16'h7FFE and 16'h8100 -> no ack, all enables stay 0 for 10 cycles.
- Back-to-back: second request with lock held high from T0 through T4 -> ignored. Request at T5 -> acknowledged at T8.
- Interrupt register (EXT_BUS_INT_EN): write 16'h0003 to 16'h7FFF -> o_inta=o_intb=1 from T1. Read -> 16'h0003. Write 16'h0000 -> both 0. Without the macro, the same access -> no ack, both interrupt lines stay 0.
- WAIT_CYCLES=1 build: read of a previously written word -> ack at T2 with correct data, proving the SRAM latency is met.

Source files
------------

// File: rtl/ext_bus_pkg.sv
// Shared definitions for the external pin-bus responder: FSM encoding,
// bus direction and lock level constants, and the window hit helper.
package ext_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_TURN = 2'd3
  } bus_state_e;

  localparam logic RW_READ   = 1'b1;
  localparam logic RW_WRITE  = 1'b0;

  localparam logic LOCK_IDLE = 1'b0;
  localparam logic LOCK_ACK  = 1'b1;

  // Window test done in 17 bits so a window ending at 16'hFFFF cannot wrap.
  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input int          bits);
    logic [16:0] lo;
    logic [16:0] hi;
    lo = {1'b0, base};
    hi = lo + (17'd1 << bits);
    return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
  endfunction

endpackage

// File: rtl/ext_bus_sram.sv
// Single-port synchronous word memory, 2^ADDR_BITS x 16, registered read.
// Contents are intentionally not reset so it maps onto block/distributed RAM.
module ext_bus_sram #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [15:0]          wdata,
  output logic [15:0]          rdata
);

  logic [15:0] mem [0:(1<<ADDR_BITS)-1];

  // One access per enabled cycle; rdata holds until the next read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/ext_bus_responder.sv
// Target side of the CPU external pin bus. Decodes a word window served
// from ext_bus_sram and, when EXT_BUS_INT_EN is defined, an interrupt
// register at INT_ADDR driving o_inta/o_intb.
// Handshake: IDLE -> WAIT (WAIT_CYCLES) -> ACK (lock driven 1) -> TURN
// (lock driven 0) -> IDLE.
module ext_bus_responder
  import ext_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h8000,
  parameter int          ADDR_BITS   = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] INT_ADDR    = 16'h7FFF
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i_rw,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_data,
  output logic [15:0] o_data,
  output logic        o_data_oe,
  input  logic        i_lock,
  output logic        o_lock,
  output logic        o_lock_oe,
  output logic        o_inta,
  output logic        o_intb
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  bus_state_e           state;
  logic [3:0]           cnt;
  logic                 rw_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [15:0]          data_q;
  logic                 int_sel_q;

  logic                 hit_mem;
  logic                 hit_int;
  logic                 accept;
  logic                 ram_en;
  logic [15:0]          ram_rdata;
  logic [15:0]          int_word;

  assign hit_mem = in_window(i_addr, BASE_ADDR, ADDR_BITS);
`ifdef EXT_BUS_INT_EN
  assign hit_int = (i_addr == INT_ADDR);
`else
  assign hit_int = 1'b0;
`endif
  assign accept  = (state == ST_IDLE) && i_lock && (hit_mem || hit_int);

  // Memory access happens only on the first WAIT cycle; the registered read
  // is then ready by ACK for any WAIT_CYCLES >= 1.
  assign ram_en = (state == ST_WAIT) && (cnt == 4'd0) && !int_sel_q;

  ext_bus_sram #(.ADDR_BITS(ADDR_BITS)) u_sram (
    .clk   (clk),
    .en    (ram_en),
    .we    (rw_q == RW_WRITE),
    .addr  (addr_q),
    .wdata (data_q),
    .rdata (ram_rdata)
  );

  // Handshake FSM with registered pin enables; reset drops enables at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      rw_q      <= RW_WRITE;
      addr_q    <= '0;
      data_q    <= 16'h0;
      int_sel_q <= 1'b0;
      o_data_oe <= 1'b0;
      o_lock    <= LOCK_IDLE;
      o_lock_oe <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_data_oe <= 1'b0;
          o_lock    <= LOCK_IDLE;
          o_lock_oe <= 1'b0;
          if (accept) begin
            rw_q      <= i_rw;
            addr_q    <= ADDR_BITS'(i_addr - BASE_ADDR);
            data_q    <= i_data;
            int_sel_q <= hit_int;
            cnt       <= 4'd0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == WAIT_LAST) begin
            cnt       <= 4'd0;
            state     <= ST_ACK;
            o_lock_oe <= 1'b1;
            o_lock    <= LOCK_ACK;
            o_data_oe <= (rw_q == RW_READ);
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_ACK: begin
          state     <= ST_TURN;
          o_lock_oe <= 1'b1;
          o_lock    <= LOCK_IDLE;
          o_data_oe <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          o_lock_oe <= 1'b0;
          o_lock    <= LOCK_IDLE;
          o_data_oe <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXT_BUS_INT_EN
  // Interrupt levels take the written value on the accepting edge and hold.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_inta <= 1'b0;
      o_intb <= 1'b0;
    end else if (accept && hit_int && (i_rw == RW_WRITE)) begin
      o_inta <= i_data[0];
      o_intb <= i_data[1];
    end
  end
`else
  assign o_inta = 1'b0;
  assign o_intb = 1'b0;
`endif

  assign int_word = {14'b0, o_intb, o_inta};
  assign o_data   = o_data_oe ? (int_sel_q ? int_word : ram_rdata) : 16'h0;

endmodule

// File: tb/tb_ext_bus_responder.sv
// Self-checking bench for ext_bus_responder. Two instances share the pin
// inputs: dut0 with WAIT_CYCLES=2, dut1 with WAIT_CYCLES=1. Expected
// per-cycle pin activity is derived from a transaction timeline model.
module tb_ext_bus_responder;

`ifdef EXT_BUS_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic        clk;
  logic        n_rst;
  logic        rw;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        lock_in;

  logic [15:0] d0_data, d1_data;
  logic        d0_doe, d1_doe, d0_lock, d1_lock, d0_loe, d1_loe;
  logic        d0_ia, d1_ia, d0_ib, d1_ib;

  ext_bus_responder #(.WAIT_CYCLES(2)) dut0 (
    .clk(clk), .n_rst(n_rst), .i_rw(rw), .i_addr(addr), .i_data(wdata),
    .o_data(d0_data), .o_data_oe(d0_doe), .i_lock(lock_in),
    .o_lock(d0_lock), .o_lock_oe(d0_loe), .o_inta(d0_ia), .o_intb(d0_ib));

  ext_bus_responder #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .n_rst(n_rst), .i_rw(rw), .i_addr(addr), .i_data(wdata),
    .o_data(d1_data), .o_data_oe(d1_doe), .i_lock(lock_in),
    .o_lock(d1_lock), .o_lock_oe(d1_loe), .o_inta(d1_ia), .o_intb(d1_ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors;
  int          miscompares;
  logic [15:0] mem_m [int];
  bit          inta_m, intb_m;
  int          written [$];

  function automatic bit is_int(input logic [15:0] a);
    return INT_EN && (a == 16'h7FFF);
  endfunction

  function automatic bit is_hit(input logic [15:0] a);
    return (a >= 16'h8000 && a < 16'h8100) || is_int(a);
  endfunction

  // One single-word transaction; every cycle of its timeline is checked.
  task automatic xact(input int wc, input bit r, input logic [15:0] a,
                      input logic [15:0] d, input string name);
    bit          hit, isint, ea, eb;
    int          n;
    logic [15:0] exp_rd, od;
    logic [2:0]  got, exp;
    logic [1:0]  gi;
    hit    = is_hit(a);
    isint  = is_int(a);
    n      = hit ? wc + 3 : 10;
    exp_rd = isint ? {14'b0, intb_m, inta_m} : (mem_m.exists(a) ? mem_m[a] : 16'h0);
    ea     = (hit && isint && !r) ? d[0] : inta_m;
    eb     = (hit && isint && !r) ? d[1] : intb_m;
    @(negedge clk);
    rw = r; addr = a; wdata = d; lock_in = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      lock_in = 1'b0;
      if (wc == 1) begin got = {d1_doe, d1_loe, d1_lock}; od = d1_data; gi = {d1_ib, d1_ia}; end
      else         begin got = {d0_doe, d0_loe, d0_lock}; od = d0_data; gi = {d0_ib, d0_ia}; end
      exp = {hit && r && k == wc + 1,
             hit && (k == wc + 1 || k == wc + 2),
             hit && k == wc + 1};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL %s wc=%0d T%0d {data_oe,lock_oe,lock} got %b exp %b", name, wc, k, got, exp);
      end
      if (exp[2]) begin
        vectors++;
        if (od !== exp_rd) begin
          miscompares++;
          $display("FAIL %s wc=%0d T%0d o_data got %h exp %h", name, wc, k, od, exp_rd);
        end
      end
      vectors++;
      if (gi !== {eb, ea}) begin
        miscompares++;
        $display("FAIL %s wc=%0d T%0d {intb,inta} got %b exp %b", name, wc, k, gi, {eb, ea});
      end
    end
    if (hit && !r) begin
      if (isint) begin inta_m = d[0]; intb_m = d[1]; end
      else begin
        if (!mem_m.exists(a)) written.push_back(int'(a));
        mem_m[a] = d;
      end
    end
  endtask

  task automatic test_reset();
    logic [35:0] got;
    n_rst = 1'b0; rw = 1'b0; addr = 16'h0; wdata = 16'h0; lock_in = 1'b0;
    repeat (3) @(negedge clk);
    got = {d0_data, d0_doe, d0_loe, d0_lock, d0_ia, d0_ib,
           d1_doe, d1_loe, d1_lock, d1_ia, d1_ib, 5'b0};
    vectors++;
    if (got !== 36'h0) begin
      miscompares++;
      $display("FAIL reset_values got %h exp 0", got);
    end
    n_rst = 1'b1;
    // Reset mid-WAIT of a write: the write was committed on the first WAIT cycle.
    @(negedge clk);
    rw = 1'b0; addr = 16'h8020; wdata = 16'h1234; lock_in = 1'b1;
    @(negedge clk); lock_in = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    vectors++;
    if ({d0_doe, d0_loe, d0_lock, d0_data} !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_mid_wait got %h exp 0", {d0_doe, d0_loe, d0_lock, d0_data});
    end
    mem_m[16'h8020] = 16'h1234; written.push_back(32'h8020);
    inta_m = 1'b0; intb_m = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    xact(2, 1'b1, 16'h8020, 16'h0, "reset_commit_read");
    // Reset during ACK: enables must drop asynchronously.
    @(negedge clk);
    rw = 1'b1; addr = 16'h8020; lock_in = 1'b1;
    @(negedge clk); lock_in = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({d0_doe, d0_loe, d0_data} !== {2'b11, 16'h1234}) begin
      miscompares++;
      $display("FAIL reset_pre_ack got %h exp %h", {d0_doe, d0_loe, d0_data}, {2'b11, 16'h1234});
    end
    n_rst = 1'b0;
    #1;
    vectors++;
    if ({d0_doe, d0_loe, d0_lock, d0_data} !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_async_drop got %h exp 0", {d0_doe, d0_loe, d0_lock, d0_data});
    end
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_write_read();
    xact(2, 1'b0, 16'h8010, 16'hA5C3, "wr_8010");
    xact(2, 1'b1, 16'h8010, 16'h0,    "rd_8010");
  endtask

  task automatic test_boundaries();
    xact(2, 1'b0, 16'h8000, 16'h1111, "wr_lo");
    xact(2, 1'b0, 16'h80FF, 16'hEEEE, "wr_hi");
    xact(2, 1'b1, 16'h8000, 16'h0,    "rd_lo");
    xact(2, 1'b1, 16'h80FF, 16'h0,    "rd_hi");
    xact(2, 1'b1, 16'h7FFE, 16'h0,    "miss_7ffe_rd");
    xact(2, 1'b0, 16'h7FFE, 16'h5555, "miss_7ffe_wr");
    xact(2, 1'b1, 16'h8100, 16'h0,    "miss_8100_rd");
    xact(2, 1'b0, 16'h8100, 16'h5555, "miss_8100_wr");
    xact(2, 1'b1, 16'hFFFF, 16'h0,    "miss_ffff_rd");
  endtask

  // Lock held high T0..T5: only the T5 sample starts a second transaction.
  task automatic test_back_to_back();
    logic [2:0] got, exp;
    @(negedge clk);
    rw = 1'b1; addr = 16'h8010; lock_in = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 6) lock_in = 1'b0;
      got = {d0_doe, d0_loe, d0_lock};
      exp = {k == 3 || k == 8, k == 3 || k == 4 || k == 8 || k == 9, k == 3 || k == 8};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL back_to_back T%0d {data_oe,lock_oe,lock} got %b exp %b", k, got, exp);
      end
      if (exp[2]) begin
        vectors++;
        if (d0_data !== mem_m[16'h8010]) begin
          miscompares++;
          $display("FAIL back_to_back T%0d o_data got %h exp %h", k, d0_data, mem_m[16'h8010]);
        end
      end
    end
  endtask

  task automatic test_interrupt();
    xact(2, 1'b0, 16'h7FFF, 16'h0003, "int_wr3");
    xact(2, 1'b1, 16'h7FFF, 16'h0,    "int_rd3");
    xact(2, 1'b0, 16'h7FFF, 16'h0002, "int_wr2");
    xact(2, 1'b1, 16'h7FFF, 16'h0,    "int_rd2");
    xact(2, 1'b0, 16'h7FFF, 16'h0000, "int_wr0");
  endtask

  task automatic test_wait1();
    xact(1, 1'b1, 16'h8010, 16'h0,    "wc1_rd_8010");
    xact(1, 1'b0, 16'h80FF, 16'h2468, "wc1_wr_80ff");
    xact(1, 1'b1, 16'h80FF, 16'h0,    "wc1_rd_80ff");
  endtask

  task automatic test_random();
    logic [15:0] a, d;
    int          wc, sel;
    for (int i = 0; i < 40; i++) begin
      wc  = int'($urandom_range(1, 2));
      sel = int'($urandom_range(0, 9));
      d   = 16'($urandom);
      if (sel < 2) begin
        a = (sel == 0) ? 16'($urandom_range(0, 16'h7FFF)) : 16'($urandom_range(16'h8100, 16'hFFFF));
        xact(wc, 1'($urandom), a, d, "rand_miss");
      end else if (sel < 6) begin
        a = 16'h8000 + 16'($urandom_range(0, 255));
        xact(wc, 1'b0, a, d, "rand_wr");
      end else begin
        a = 16'(written[$urandom_range(0, written.size() - 1)]);
        xact(wc, 1'b1, a, 16'h0, "rand_rd");
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; inta_m = 1'b0; intb_m = 1'b0;
    test_reset();
    test_write_read();
    test_boundaries();
    test_back_to_back();
    test_interrupt();
    test_wait1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
